// File: rtl/pack_fifo_pkg.sv
// Shared constants and sizing helpers for the width-packing FIFO.
// Optional synchronous flush port is enabled with the PACK_FIFO_FLUSH_EN macro.
package pack_fifo_pkg;

  localparam int DEF_IN_W  = 4;
  localparam int DEF_RATIO = 2;
  localparam int DEF_DEPTH = 16;

  // Packing order: which end of data_out receives the oldest input word.
  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy must represent the full value DEPTH, hence one extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pack_fifo_mem.sv
// DEPTH x IN_W storage with one write port and a RATIO-entry wrapped gather
// read port that assembles the packed OUT_W word in the selected order.
module pack_fifo_mem
  import pack_fifo_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int RATIO     = DEF_RATIO,
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST,
  localparam int AW       = ptr_w(DEPTH),
  localparam int OUT_W    = IN_W * RATIO
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [IN_W-1:0]  wdata,
  input  logic [AW-1:0]    raddr,
  output logic [OUT_W-1:0] rdata
);

  logic [IN_W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; occupancy tracking guarantees stale entries are
  // never presented, and leaving it unreset lets the array map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // DEPTH is a power of two, so the AW-bit address sum wraps on its own.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (MSB_FIRST) rdata[(RATIO-1-i)*IN_W +: IN_W] = mem_q[raddr + AW'(i)];
      else           rdata[i*IN_W +: IN_W]           = mem_q[raddr + AW'(i)];
    end
  end

endmodule

// File: rtl/pack_fifo.sv
// Width-packing FIFO top: pointers, occupancy, handshake decode and flush.
// Define PACK_FIFO_FLUSH_EN to add the synchronous flush input.
module pack_fifo
  import pack_fifo_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int RATIO     = DEF_RATIO,
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST,
  localparam int OUT_W    = IN_W * RATIO,
  localparam int AW       = ptr_w(DEPTH),
  localparam int CW       = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PACK_FIFO_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_v,
  output logic             in_en,
  input  logic [IN_W-1:0]  data_in,
  output logic             out_v,
  input  logic             out_en,
  output logic [OUT_W-1:0] data_out,
  output logic [CW-1:0]    count
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             flush_i;
  logic             wr_xfer, rd_xfer;
  logic [OUT_W-1:0] gather;

`ifdef PACK_FIFO_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Enables come from registered occupancy only, so there is no in_v/out_en bypass.
  assign in_en    = (count_q < CW'(DEPTH)) && !flush_i;
  assign out_v    = (count_q >= CW'(RATIO)) && !flush_i;
  assign wr_xfer  = in_v && in_en;
  assign rd_xfer  = out_v && out_en;
  assign count    = count_q;
  assign data_out = out_v ? gather : '0;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_xfer) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_xfer) rd_ptr_d = rd_ptr_q + AW'(RATIO);
      count_d = count_q + CW'(wr_xfer) - (rd_xfer ? CW'(RATIO) : CW'(0));
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  pack_fifo_mem #(
    .IN_W      (IN_W),
    .RATIO     (RATIO),
    .DEPTH     (DEPTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_mem (
    .clk   (clk),
    .we    (wr_xfer),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (gather)
  );

endmodule

// File: tb/tb_pack_fifo.sv
// Directed self-checking bench for pack_fifo (default and LSB-first packing side by side).
// Flush scenario runs only when PACK_FIFO_FLUSH_EN is defined.
module tb_pack_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_v;
  logic       out_en;
  logic [3:0] data_in;
  logic       in_en, out_v, in_en_l, out_v_l;
  logic [7:0] data_out, data_out_l;
  logic [4:0] count, count_l;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pack_fifo dut (
    .clk      (clk),
    .rst      (rst),
`ifdef PACK_FIFO_FLUSH_EN
    .flush    (flush),
`endif
    .in_v     (in_v),
    .in_en    (in_en),
    .data_in  (data_in),
    .out_v    (out_v),
    .out_en   (out_en),
    .data_out (data_out),
    .count    (count)
  );

  pack_fifo #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk      (clk),
    .rst      (rst),
`ifdef PACK_FIFO_FLUSH_EN
    .flush    (flush),
`endif
    .in_v     (in_v),
    .in_en    (in_en_l),
    .data_in  (data_in),
    .out_v    (out_v_l),
    .out_en   (out_en),
    .data_out (data_out_l),
    .count    (count_l)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] w);
    in_v = 1'b1; data_in = w;
    step();
    in_v = 1'b0;
  endtask

  task automatic pop();
    out_en = 1'b1;
    step();
    out_en = 1'b0;
  endtask

  task automatic test_reset();
    // {count, in_en, out_v, data_out}
    n_tests++;
    if ({count, in_en, out_v, data_out} !== {5'd0, 1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got cnt=%0d in_en=%b out_v=%b dout=%h want 0 1 0 00",
               count, in_en, out_v, data_out);
    end
    push(4'h1); push(4'h2); push(4'h3);
    n_tests++;
    if ({count, out_v, data_out} !== {5'd3, 1'b1, 8'h12}) begin
      n_fail++;
      $display("FAIL pre_reset: got cnt=%0d out_v=%b dout=%h want 3 1 12", count, out_v, data_out);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({count, in_en, out_v, data_out} !== {5'd0, 1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL async_reset: got cnt=%0d in_en=%b out_v=%b dout=%h want 0 1 0 00",
               count, in_en, out_v, data_out);
    end
    #1 rst = 1'b0;
    step();
  endtask

  task automatic test_packing();
    push(4'hA);
    n_tests++;
    if ({count, out_v, data_out} !== {5'd1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL partial_word: got cnt=%0d out_v=%b dout=%h want 1 0 00", count, out_v, data_out);
    end
    push(4'hB);
    n_tests++;
    if ({out_v, data_out} !== {1'b1, 8'hAB}) begin
      n_fail++;
      $display("FAIL msb_first: got out_v=%b dout=%h want 1 ab", out_v, data_out);
    end
    n_tests++;
    if ({out_v_l, data_out_l} !== {1'b1, 8'hBA}) begin
      n_fail++;
      $display("FAIL lsb_first: got out_v=%b dout=%h want 1 ba", out_v_l, data_out_l);
    end
    pop();
    n_tests++;
    if ({count, out_v, data_out} !== {5'd0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL pack_drain: got cnt=%0d out_v=%b dout=%h want 0 0 00", count, out_v, data_out);
    end
  endtask

  task automatic test_full_wrap();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) push(4'(i));
    n_tests++;
    if ({count, in_en} !== {5'd16, 1'b0}) begin
      n_fail++;
      $display("FAIL full: got cnt=%0d in_en=%b want 16 0", count, in_en);
    end
    push(4'h5);
    n_tests++;
    if ({count, data_out} !== {5'd16, 8'h01}) begin
      n_fail++;
      $display("FAIL overflow_ignored: got cnt=%0d dout=%h want 16 01", count, data_out);
    end
    for (int k = 0; k < 8; k++) begin
      exp = {4'(2*k), 4'(2*k+1)};
      n_tests++;
      if ({out_v, data_out} !== {1'b1, exp}) begin
        n_fail++;
        $display("FAIL drain_%0d: got out_v=%b dout=%h want 1 %h", k, out_v, data_out, exp);
      end
      pop();
    end
    n_tests++;
    if ({count, out_v, in_en} !== {5'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL drained: got cnt=%0d out_v=%b in_en=%b want 0 0 1", count, out_v, in_en);
    end
    for (int i = 0; i < 16; i++) push(4'(15 - i));
    n_tests++;
    if ({count, in_en, data_out} !== {5'd16, 1'b0, 8'hFE}) begin
      n_fail++;
      $display("FAIL refill: got cnt=%0d in_en=%b dout=%h want 16 0 fe", count, in_en, data_out);
    end
  endtask

  task automatic test_full_read();
    logic [7:0] exp;
    in_v = 1'b1; data_in = 4'h7; out_en = 1'b1;
    step();
    in_v = 1'b0; out_en = 1'b0;
    n_tests++;
    if ({count, in_en, data_out} !== {5'd14, 1'b1, 8'hDC}) begin
      n_fail++;
      $display("FAIL full_rd_wr: got cnt=%0d in_en=%b dout=%h want 14 1 dc", count, in_en, data_out);
    end
    for (int k = 1; k < 8; k++) begin
      exp = {4'(15 - 2*k), 4'(14 - 2*k)};
      n_tests++;
      if (data_out !== exp) begin
        n_fail++;
        $display("FAIL rewrap_%0d: got dout=%h want %h", k, data_out, exp);
      end
      pop();
    end
    n_tests++;
    if ({count, out_v} !== {5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL refused_write: got cnt=%0d out_v=%b want 0 0", count, out_v);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 1; i <= 5; i++) push(4'(i));
    n_tests++;
    if ({count, data_out, data_out_l} !== {5'd5, 8'h12, 8'h21}) begin
      n_fail++;
      $display("FAIL sim_setup: got cnt=%0d dout=%h dout_l=%h want 5 12 21", count, data_out, data_out_l);
    end
    in_v = 1'b1; data_in = 4'h6; out_en = 1'b1;
    step();
    in_v = 1'b0; out_en = 1'b0;
    n_tests++;
    if ({count, data_out} !== {5'd4, 8'h34}) begin
      n_fail++;
      $display("FAIL sim_rd_wr: got cnt=%0d dout=%h want 4 34", count, data_out);
    end
    pop();
    n_tests++;
    if ({count, data_out} !== {5'd2, 8'h56}) begin
      n_fail++;
      $display("FAIL sim_stored: got cnt=%0d dout=%h want 2 56", count, data_out);
    end
    pop();
  endtask

  task automatic test_back_to_back();
    // Write every cycle with out_en held: pairs pop as soon as two words are present.
    out_en = 1'b1;
    push(4'h8);
    push(4'h9);
    n_tests++;
    if ({count, data_out} !== {5'd2, 8'h89}) begin
      n_fail++;
      $display("FAIL b2b_first: got cnt=%0d dout=%h want 2 89", count, data_out);
    end
    push(4'hA);
    n_tests++;
    if ({count, out_v} !== {5'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_pop: got cnt=%0d out_v=%b want 1 0", count, out_v);
    end
    push(4'hB);
    n_tests++;
    if ({count, data_out} !== {5'd2, 8'hAB}) begin
      n_fail++;
      $display("FAIL b2b_second: got cnt=%0d dout=%h want 2 ab", count, data_out);
    end
    step();
    out_en = 1'b0;
    n_tests++;
    if (count !== 5'd0) begin
      n_fail++;
      $display("FAIL b2b_end: got cnt=%0d want 0", count);
    end
  endtask

`ifdef PACK_FIFO_FLUSH_EN
  task automatic test_flush();
    for (int i = 0; i < 7; i++) push(4'(i));
    flush = 1'b1; in_v = 1'b1; data_in = 4'hC; out_en = 1'b1;
    #1;
    n_tests++;
    if ({in_en, out_v, data_out} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL flush_gate: got in_en=%b out_v=%b dout=%h want 0 0 00", in_en, out_v, data_out);
    end
    step();
    flush = 1'b0; in_v = 1'b0; out_en = 1'b0;
    #1;
    n_tests++;
    if ({count, in_en, out_v} !== {5'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_clear: got cnt=%0d in_en=%b out_v=%b want 0 1 0", count, in_en, out_v);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; in_v = 1'b0; out_en = 1'b0; data_in = '0;
    #12 rst = 1'b0;
    #1;
    test_reset();
    test_packing();
    test_full_wrap();
    test_full_read();
    test_simultaneous();
    test_back_to_back();
`ifdef PACK_FIFO_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pack_fifo.md
# pack_fifo

Parametrised width-packing FIFO: accepts narrow input words over a valid/enable handshake and returns packed output words of RATIO input words each, in arrival order. It generalises the fixed 4-bit-in / 8-bit-out buffer with configurable width, depth and packing order, true full/empty flow control and simultaneous read/write. It sits between a narrow producer (serial or nibble-wide source) and a wider consumer datapath.

## Interface
- IN_W, 4, input word width in bits
- RATIO, 2, input words per output word; OUT_W = IN_W*RATIO
- DEPTH, 16, storage depth in input words; power of 2, multiple of RATIO, at least 2*RATIO
- MSB_FIRST, 1, 1: first-arrived input word lands in the top IN_W bits of data_out; 0: in bits [IN_W-1:0]

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_v  in  1  producer has data_in valid
- in_en  out  1  FIFO can accept one input word (not full)
- data_in  in  IN_W  input word
- out_v  out  1  at least one packed word available
- out_en  in  1  consumer takes the packed word
- data_out  out  OUT_W  packed output word
- count  out  $clog2(DEPTH)+1  occupancy in input words
- flush  in  1  synchronous clear; present only with PACK_FIFO_FLUSH_EN

## Operation
- Write transfer: in_v && in_en at a rising edge; data_in stored at wr_ptr; wr_ptr += 1, wrapping modulo DEPTH.
- Read transfer: out_v && out_en at a rising edge; rd_ptr += RATIO, wrapping modulo DEPTH.
- in_en = (count < DEPTH); out_v = (count >= RATIO); both decoded from registered count only, no combinational path from in_v/out_en.
- data_out is show-ahead: entries rd_ptr .. rd_ptr+RATIO-1 concatenated per MSB_FIRST whenever out_v=1; forced to 0 when out_v=0.
- Simultaneous write and read in one cycle: both take effect; count <= count + 1 - RATIO.
- Full (count=DEPTH): in_en=0; a read in the same cycle does not re-enable in_en until the next cycle (no bypass).
- Empty or partial (count<RATIO): out_v=0; a write in the same cycle does not produce out_v until the next cycle (no bypass).
- Handshake ignored when the enable side is low: in_v with in_en=0 or out_en with out_v=0 changes nothing.
- count never exceeds DEPTH and never underflows; any attempt is structurally impossible by the enables.
- Reset (asynchronous, any time, including mid-transfer): count=0, wr_ptr=0, rd_ptr=0; storage not cleared. Output values in reset: in_en=1, out_v=0, data_out=0, count=0.

## Timing
- Write-to-visible latency: the RATIO-th word written at edge N makes out_v=1 after edge N (usable at edge N+1).
- Read-to-space latency: read at edge N raises in_en after edge N if the FIFO was full.
- Sustained throughput: 1 input word per cycle; 1 output word per cycle while count>=RATIO.
- All outputs change only after clk rising edge or on rst assertion.

## Configuration
- PACK_FIFO_FLUSH_EN defined: flush port exists; flush=1 at an edge clears count, wr_ptr, rd_ptr; overrides any write/read in that cycle; while flush=1, in_en=0 and out_v=0 so no handshake completes; data_out=0.
- Undefined: no flush port; only rst clears state.

## Structure
- Package pack_fifo_pkg: default parameter constants, pointer/count width helper function (clog2-based), MSB_FIRST encoding constants.
- Sub-module pack_fifo_mem: DEPTH x IN_W register array, one write port, RATIO-entry wrapped gather read port producing the OUT_W word in the selected order. Top level holds pointers, count, handshake decode, flush.

## Test plan
- Reset mid-stream: write 3 words, assert rst asynchronously between edges -> count=0, out_v=0, in_en=1, data_out=0 immediately.
- Packing order: defaults, write 0xA then 0xB -> out_v=1 next cycle, data_out=0xAB; with MSB_FIRST=0 -> 0xBA.
- Full and wrap: write 16 words 0x0..0xF, out_en=0 -> count=16, in_en=0, 17th in_v ignored; read 8 words -> 0x01,0x23,...,0xEF; rewrite across wrap -> order preserved.
- Simultaneous: count=5, in_v=1 and out_en=1 same edge -> count=4, correct pair popped, new word stored.
- Full with read: count=16, in_v=1 and out_en=1 same edge -> read occurs, write refused, count=14, in_en=1 next cycle.
- Flush (PACK_FIFO_FLUSH_EN): count=7, flush=1 with in_v=1, out_en=1 -> count=0, no transfer, out_v=0, in_en=1 after flush drops.
